hwpe_instr_seq: RTL and testbench

Hardware command sequencer for the HWPE convolution engine. Latches one layer's configuration words and emits the full custom-instruction stream (reset, config, feature-map bases, accumulator clear, matrix kick-off, then per-tile accumulator readout or ReLU write-back) on a valid/ready command port feeding the HWPE core's instruction decoder. It replaces software or bench-side stream generation and runs one layer per `start` pulse.

---
 rtl/hwpe_instr_pkg.sv | 46 ++++
 rtl/hwpe_loop_cnt.sv | 63 ++++++
 rtl/hwpe_instr_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_hwpe_instr_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_instr_pkg.sv
// Shared encoding constants for the HWPE custom-instruction stream.
// The core decoder and the sequencer both import this package.
package hwpe_instr_pkg;

    localparam logic [6:0] F7_RESET  = 7'd64;
    localparam logic [6:0] F7_WCFG   = 7'd2;
    localparam logic [6:0] F7_WFAD   = 7'd1;
    localparam logic [6:0] F7_WACC   = 7'd8;
    localparam logic [6:0] F7_MATRIX = 7'd4;
    localparam logic [6:0] F7_RACC   = 7'd16;
    localparam logic [6:0] F7_RELU   = 7'd32;

    // xd/xs1/xs2 bits in instr[14:12]
    localparam logic [2:0] XS_NONE    = 3'b000;
    localparam logic [2:0] XS_RS1_RS2 = 3'b011;
    localparam logic [2:0] XS_RS1     = 3'b010;
    localparam logic [2:0] XS_XD      = 3'b100;

    localparam int unsigned CFG1_KSIZE_LSB = 0;
    localparam int unsigned CFG1_DTYPE_LSB = 4;
    localparam int unsigned CFG1_LTYPE_BIT = 6;
    localparam int unsigned CFG1_K333_BIT  = 7;
    localparam int unsigned CFG1_SHIFT_LSB = 8;
    localparam int unsigned CFG1_KCNT_LSB  = 13;
    localparam int unsigned CFG1_KCNT_W    = 10;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StWcfg,
        StWfad,
        StWacc,
        StMatrix,
        StTile
    } seq_state_e;

    // Instruction bits [31:7]; the opcode is appended by the user.
    function automatic logic [24:0] instr_fields(input logic [6:0] funct7,
                                                 input logic [4:0] rs2,
                                                 input logic [4:0] rs1,
                                                 input logic [2:0] xs,
                                                 input logic [4:0] rd);
        return {funct7, rs2, rs1, xs, rd};
    endfunction

endpackage

// File: rtl/hwpe_loop_cnt.sv
// Three-level K/W/H tile counter (h innermost). final_nxt_o looks ahead to the
// tile held after the pending clr/inc so the sequencer can encode registered outputs.
module hwpe_loop_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        inc_i,
    input  logic [9:0]  k_cnt_i,
    input  logic [15:0] w_cnt_i,
    input  logic [15:0] h_cnt_i,
    output logic        final_o,
    output logic        final_nxt_o
);

    logic [9:0]  k_q, k_d;
    logic [15:0] w_q, w_d;
    logic [15:0] h_q, h_d;
    logic        k_last, w_last, h_last;

    assign k_last = (k_q == k_cnt_i - 10'd1);
    assign w_last = (w_q == w_cnt_i - 16'd1);
    assign h_last = (h_q == h_cnt_i - 16'd1);

    always_comb begin
        k_d = k_q;
        w_d = w_q;
        h_d = h_q;
        if (clr_i) begin
            k_d = '0;
            w_d = '0;
            h_d = '0;
        end else if (inc_i) begin
            if (!h_last) begin
                h_d = h_q + 16'd1;
            end else begin
                h_d = '0;
                if (!w_last) begin
                    w_d = w_q + 16'd1;
                end else begin
                    w_d = '0;
                    k_d = k_q + 10'd1;
                end
            end
        end
    end

    assign final_o     = k_last && w_last && h_last;
    assign final_nxt_o = (k_d == k_cnt_i - 10'd1) && (w_d == w_cnt_i - 16'd1)
                         && (h_d == h_cnt_i - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
            w_q <= '0;
            h_q <= '0;
        end else begin
            k_q <= k_d;
            w_q <= w_d;
            h_q <= h_d;
        end
    end

endmodule

// File: rtl/hwpe_instr_seq.sv
// Layer command sequencer: latches a layer configuration on start and streams the
// full HWPE custom-instruction sequence over a valid/ready port, one layer per start.
module hwpe_instr_seq
    import hwpe_instr_pkg::*;
#(
    parameter logic [6:0]  OPCODE = 7'b0001011,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned PES    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  cfg0,
    input  logic [31:0]  cfg1,
    input  logic [31:0]  vrs1,
    input  logic [31:0]  vrs2,
    input  logic [255:0] base_addr,
    input  logic         relu_mode,
    input  logic [31:0]  relu_waddr,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [31:0]  cmd_instr,
    output logic [31:0]  cmd_rs1,
    output logic [31:0]  cmd_rs2,
    output logic         busy,
    output logic         done
);

    localparam logic [2:0] RowMax = 3'(ROWS - 1);
    localparam logic [3:0] PeMax  = 4'(PES - 1);

    seq_state_e   state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [2:0]   row_q, row_d;
    logic [3:0]   pe_q, pe_d;
    logic [31:0]  cfg0_q, cfg0_d, cfg1_q, cfg1_d, vrs1_q, vrs1_d, vrs2_q, vrs2_d;
    logic [255:0] base_q, base_d;
    logic         relu_q, relu_d;
    logic [31:0]  waddr_q, waddr_d;
    logic         cmd_valid_q, cmd_valid_d, busy_q, busy_d, done_q, done_d;
    logic [31:0]  instr_q, instr_d, rs1_q, rs1_d, rs2_q, rs2_d;

    logic         fire, out_load, tile_last, tile_last_n, tile_skip;
    logic         loop_clr, loop_inc, loop_final, loop_final_nxt;
    logic [4:0]   acc_n;

    function automatic logic [31:0] enc(input logic [6:0] funct7, input logic [4:0] rs2f,
                                        input logic [4:0] rs1f, input logic [2:0] xs,
                                        input logic [4:0] rd);
        return {instr_fields(funct7, rs2f, rs1f, xs, rd), OPCODE};
    endfunction

    assign fire      = cmd_valid_q && cmd_ready;
    assign out_load  = ((state_q == StIdle) && start) || fire;
    assign tile_last = relu_q ? (row_q == RowMax) : ((row_q == RowMax) && (pe_q == PeMax));
    assign tile_skip = (cfg1_q[CFG1_KCNT_LSB +: CFG1_KCNT_W] == '0) || (vrs1_q[31:16] == '0)
                       || (vrs1_q[15:0] == '0);
    assign loop_clr  = (state_q == StIdle) && start;
    assign loop_inc  = fire && (state_q == StTile) && tile_last && !loop_final;

    hwpe_loop_cnt u_loop_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (loop_clr),
        .inc_i       (loop_inc),
        .k_cnt_i     (cfg1_q[CFG1_KCNT_LSB +: CFG1_KCNT_W]),
        .w_cnt_i     (vrs1_q[31:16]),
        .h_cnt_i     (vrs1_q[15:0]),
        .final_o     (loop_final),
        .final_nxt_o (loop_final_nxt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        pe_d    = pe_q;
        cfg0_d  = cfg0_q;
        cfg1_d  = cfg1_q;
        vrs1_d  = vrs1_q;
        vrs2_d  = vrs2_q;
        base_d  = base_q;
        relu_d  = relu_q;
        waddr_d = waddr_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cfg0_d  = cfg0;
                    cfg1_d  = cfg1;
                    vrs1_d  = vrs1;
                    vrs2_d  = vrs2;
                    base_d  = base_addr;
                    relu_d  = relu_mode;
                    waddr_d = relu_waddr;
                    idx_d   = '0;
                    row_d   = '0;
                    pe_d    = '0;
                    state_d = StRst;
                end
            end
            StRst:  if (fire) state_d = StWcfg;
            StWcfg: if (fire) state_d = StWfad;
            StWfad: begin
                if (fire) begin
                    if (idx_q == 2'd3) state_d = StWacc;
                    else               idx_d   = idx_q + 2'd1;
                end
            end
            StWacc: begin
                if (fire) begin
                    if (pe_q == PeMax) begin
                        pe_d = '0;
                        if (row_q == RowMax) begin
                            row_d   = '0;
                            state_d = StMatrix;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        pe_d = pe_q + 4'd1;
                    end
                end
            end
            StMatrix: begin
                if (fire) begin
                    state_d = tile_skip ? StIdle : StTile;
                    done_d  = tile_skip;
                end
            end
            StTile: begin
                if (fire) begin
                    if (tile_last) begin
                        row_d = '0;
                        pe_d  = '0;
                        if (loop_final) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else if (relu_q) begin
                        row_d = row_q + 3'd1;
                    end else if (pe_q == PeMax) begin
                        pe_d  = '0;
                        row_d = row_q + 3'd1;
                    end else begin
                        pe_d = pe_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output registers are loaded with the command selected by the next-state values.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        busy_d      = (state_d != StIdle);
        tile_last_n = relu_q ? (row_d == RowMax) : ((row_d == RowMax) && (pe_d == PeMax));
        acc_n       = (tile_last_n && !loop_final_nxt) ? {2'b10, row_d} : {2'b00, row_d};
        if (out_load) begin
            cmd_valid_d = 1'b1;
            instr_d     = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            case (state_d)
                StRst:  instr_d = enc(F7_RESET, 5'd0, 5'd0, XS_NONE, 5'd0);
                StWcfg: begin
                    instr_d = enc(F7_WCFG, 5'd0, 5'd0, XS_RS1_RS2, 5'd0);
                    rs1_d   = cfg0_q;
                    rs2_d   = cfg1_q;
                end
                StWfad: begin
                    instr_d = enc(F7_WFAD, 5'd0, 5'd0, XS_RS1_RS2, {2'b00, idx_d, 1'b0});
                    rs1_d   = base_q[{idx_d, 6'd0} +: 32];
                    rs2_d   = base_q[{idx_d, 6'd32} +: 32];
                end
                StWacc: instr_d = enc(F7_WACC, {1'b0, pe_d}, 5'd0, XS_RS1, {2'b00, row_d});
                StMatrix: begin
                    instr_d = enc(F7_MATRIX, 5'd0, 5'd0, XS_RS1_RS2, 5'd0);
                    rs1_d   = vrs1_q;
                    rs2_d   = vrs2_q;
                end
                StTile: begin
                    if (relu_q) begin
                        instr_d = enc(F7_RELU, acc_n, 5'd0, XS_RS1, 5'd0);
                        rs1_d   = waddr_q;
                    end else begin
                        instr_d = enc(F7_RACC, {1'b0, pe_d}, acc_n, XS_XD, 5'd0);
                    end
                end
                default: cmd_valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            row_q       <= '0;
            pe_q        <= '0;
            cfg0_q      <= '0;
            cfg1_q      <= '0;
            vrs1_q      <= '0;
            vrs2_q      <= '0;
            base_q      <= '0;
            relu_q      <= 1'b0;
            waddr_q     <= '0;
            cmd_valid_q <= 1'b0;
            instr_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            pe_q        <= pe_d;
            cfg0_q      <= cfg0_d;
            cfg1_q      <= cfg1_d;
            vrs1_q      <= vrs1_d;
            vrs2_q      <= vrs2_d;
            base_q      <= base_d;
            relu_q      <= relu_d;
            waddr_q     <= waddr_d;
            cmd_valid_q <= cmd_valid_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_instr = instr_q;
    assign cmd_rs1   = rs1_q;
    assign cmd_rs2   = rs2_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hwpe_instr_seq.sv
// Scoreboard bench for hwpe_instr_seq: the expected command stream is queued at
// start and checked command-by-command as the sequencer fires.
module tb_hwpe_instr_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  cfg0, cfg1, vrs1, vrs2, relu_waddr;
    logic [255:0] base_addr;
    logic         relu_mode;
    logic         cmd_valid, cmd_ready, busy, done;
    logic [31:0]  cmd_instr, cmd_rs1, cmd_rs2;

    always #5 clk = ~clk;

    hwpe_instr_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg0       (cfg0),
        .cfg1       (cfg1),
        .vrs1       (vrs1),
        .vrs2       (vrs2),
        .base_addr  (base_addr),
        .relu_mode  (relu_mode),
        .relu_waddr (relu_waddr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_instr  (cmd_instr),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .busy       (busy),
        .done       (done)
    );

    int          n_total = 0;
    int          n_bad = 0;
    logic [95:0] exp_q[$];
    int          n_cmd = 0, n_done = 0, n_flag = 0, n_gap = 0, n_busy_bad = 0;
    logic [31:0] last_instr = '0;
    logic        held_v = 1'b0;
    logic [95:0] held = '0;
    logic        bp_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                        input logic [4:0] rs1f, input logic [2:0] xs,
                                        input logic [4:0] rd);
        return {f7, rs2f, rs1f, xs, rd, 7'b0001011};
    endfunction

    // Reference model of the layer stream built from the currently driven inputs.
    task automatic push_layer();
        int          nk, nw, nh, nt;
        logic [4:0]  acc;
        exp_q.push_back({enc(7'd64, 5'd0, 5'd0, 3'b000, 5'd0), 64'h0});
        exp_q.push_back({enc(7'd2, 5'd0, 5'd0, 3'b011, 5'd0), cfg0, cfg1});
        for (int i = 0; i < 4; i++)
            exp_q.push_back({enc(7'd1, 5'd0, 5'd0, 3'b011, 5'(2 * i)),
                             base_addr[64 * i +: 32], base_addr[64 * i + 32 +: 32]});
        for (int r = 0; r < 8; r++)
            for (int p = 0; p < 16; p++)
                exp_q.push_back({enc(7'd8, 5'(p), 5'd0, 3'b010, 5'(r)), 64'h0});
        exp_q.push_back({enc(7'd4, 5'd0, 5'd0, 3'b011, 5'd0), vrs1, vrs2});
        nk = int'(cfg1[22:13]);
        nw = int'(vrs1[31:16]);
        nh = int'(vrs1[15:0]);
        nt = nk * nw * nh;
        for (int t = 0; t < nt; t++) begin
            for (int r = 0; r < 8; r++) begin
                if (relu_mode) begin
                    acc = (r == 7 && t != nt - 1) ? 5'(16 + r) : 5'(r);
                    exp_q.push_back({enc(7'd32, acc, 5'd0, 3'b010, 5'd0), relu_waddr, 32'h0});
                end else begin
                    for (int p = 0; p < 16; p++) begin
                        acc = (r == 7 && p == 15 && t != nt - 1) ? 5'(16 + r) : 5'(r);
                        exp_q.push_back({enc(7'd16, 5'(p), acc, 3'b100, 5'd0), 64'h0});
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        logic [95:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
            return;
        end
        if (held_v) begin
            check_eq("hold_valid", 32'(cmd_valid), 32'd1);
            check_eq("hold_instr", cmd_instr, held[95:64]);
            check_eq("hold_rs1", cmd_rs1, held[63:32]);
            check_eq("hold_rs2", cmd_rs2, held[31:0]);
        end
        if (cmd_valid && cmd_ready) begin
            n_cmd++;
            last_instr = cmd_instr;
            if (cmd_instr == 32'h4170200B) n_flag++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_cmd_instr", cmd_instr, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_instr", cmd_instr, e[95:64]);
                check_eq("sb_rs1", cmd_rs1, e[63:32]);
                check_eq("sb_rs2", cmd_rs2, e[31:0]);
            end
        end
        held_v = cmd_valid && !cmd_ready;
        held   = {cmd_instr, cmd_rs1, cmd_rs2};
        if (done) begin
            n_done++;
            check_eq("done_valid_low", 32'(cmd_valid), 32'd0);
            check_eq("done_busy_low", 32'(busy), 32'd0);
        end
        if (busy && !cmd_valid) n_gap++;
        if (cmd_valid && !busy) n_busy_bad++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start     = 1'b0;
        cmd_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        monitor();
    endtask

    task automatic set_cfg(input logic [9:0] k, input logic [15:0] w, input logic [15:0] h,
                           input logic relu, input logic [31:0] waddr);
        cfg0 = $urandom;
        cfg1 = {9'b0, k, 13'($urandom)};
        vrs1 = {w, h};
        vrs2 = $urandom;
        for (int i = 0; i < 8; i++) base_addr[32 * i +: 32] = $urandom;
        relu_mode  = relu;
        relu_waddr = waddr;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check_eq({tag, "_instr"}, cmd_instr, 32'd0);
        check_eq({tag, "_rs1"}, cmd_rs1, 32'd0);
        check_eq({tag, "_rs2"}, cmd_rs2, 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // poke_at > 0: at that cycle the inputs are scrambled and start is pulsed while busy.
    task automatic run_layer(input string name, input int exp_n, input int poke_at,
                             output int cycles);
        int   c0, d0;
        logic got;
        push_layer();
        c0     = n_cmd;
        d0     = n_done;
        start  = 1'b1;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 30000) begin
            step();
            cycles++;
            if (done) got = 1'b1;
            if (cycles == poke_at) begin
                set_cfg(10'd2, 16'd3, 16'd1, ~relu_mode, 32'h0000_0055);
                start = 1'b1;
            end
        end
        check_eq({name, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) step();
        check_eq({name, "_cmd_count"}, n_cmd - c0, exp_n);
        check_eq({name, "_done_count"}, n_done - d0, 32'd1);
        check_eq({name, "_queue_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int cyc, g0, f0, c0, d0;
        cmd_ready = 1'b1;
        set_cfg(10'd1, 16'd1, 16'd1, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        g0 = n_gap;
        set_cfg(10'd1, 16'd1, 16'd1, 1'b0, 32'd0);
        run_layer("base", 263, -1, cyc);
        check_eq("base_cycles", cyc, 32'd264);
        check_eq("base_last", last_instr, 32'h20F3C00B);
        check_eq("base_gaps", n_gap - g0, 32'd0);

        f0 = n_flag;
        set_cfg(10'd1, 16'd2, 16'd2, 1'b1, 32'd128);
        run_layer("relu", 167, -1, cyc);
        check_eq("relu_last", last_instr, 32'h4070200B);
        check_eq("relu_flags", n_flag - f0, 32'd3);

        bp_en = 1'b1;
        set_cfg(10'd1, 16'd1, 16'd1, 1'b0, 32'd0);
        run_layer("bp_racc", 263, -1, cyc);
        set_cfg(10'd2, 16'd1, 16'd2, 1'b1, 32'hDEAD_0000);
        run_layer("bp_relu", 167, -1, cyc);
        bp_en = 1'b0;

        set_cfg(10'd1, 16'd1, 16'd0, 1'b0, 32'd0);
        run_layer("h0", 135, -1, cyc);
        check_eq("h0_last", last_instr, 32'h0800300B);

        set_cfg(10'd1, 16'd1, 16'd1, 1'b0, 32'd0);
        push_layer();
        c0    = n_cmd;
        d0    = n_done;
        start = 1'b1;
        cyc   = 0;
        while (n_cmd - c0 < 50 && cyc < 1000) begin
            step();
            cyc++;
        end
        check_eq("abort_reached", n_cmd - c0, 32'd50);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort_rst");
        repeat (2) step();
        exp_q.delete();
        rst_n = 1'b1;
        repeat (4) step();
        check_eq("abort_no_done", n_done - d0, 32'd0);
        check_eq("abort_idle_valid", 32'(cmd_valid), 32'd0);
        set_cfg(10'd1, 16'd1, 16'd2, 1'b1, 32'd77);
        run_layer("restart", 151, -1, cyc);

        set_cfg(10'd2, 16'd1, 16'd1, 1'b0, 32'd0);
        run_layer("poke", 391, 40, cyc);
        check_eq("poke_cycles", cyc, 32'd392);
        check_eq("busy_with_valid", n_busy_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
